hamming_serial_tx: RTL and testbench

Single-lane transmit end of the strobed serial Hamming(7,4) link. Accepts 4-bit words over a valid/ready handshake, buffers up to two of them, encodes each into a 7-bit Hamming codeword, and shifts it out one bit per clock under a high `strobe`. It sits upstream of the error-injection and error-correction lanes and produces the `strobe`/`d_out` pair those receivers consume. Each frame is closed by a low-strobe gap.

---
 rtl/hamming_serial_tx.sv | 79 +++++++
 tb/tb_hamming_serial_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hamming_serial_tx.sv
// hamming_serial_tx: buffers 4-bit words and shifts out strobed Hamming(7,4) codewords
module hamming_serial_tx #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       strobe,
  output logic       d_out,
  output logic       busy,
  output logic [7:0] frames_sent
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_n;
  logic [3:0] mem [2];
  logic       wp, rp, push, pop, gap_done;
  logic [1:0] count;
  logic [3:0] head, gcnt, gcnt_n;
  logic [6:0] cw, sr, sr_n;
  logic [2:0] idx, idx_n;
  assign in_ready = count < 2'd2;
  assign busy = state != IDLE || count != 2'd0;
  assign push = in_valid && in_ready;
  assign gap_done = state == GAP && gcnt == 4'd1;
  assign pop = (state == IDLE || gap_done) && count != 2'd0;
  assign head = mem[rp];
  assign cw = {head[3], head[2], head[1], head[1] ^ head[2] ^ head[3],
               head[0], head[0] ^ head[2] ^ head[3], head[0] ^ head[1] ^ head[3]};
  always_comb begin
    state_n = state;
    sr_n = sr;
    idx_n = idx;
    gcnt_n = gcnt;
    if (pop) begin
      state_n = SEND;
      sr_n = cw;
      idx_n = 3'd0;
    end else if (state == SEND) begin
      state_n = idx == 3'd6 ? GAP : SEND;
      gcnt_n = idx == 3'd6 ? 4'(GAP_CYCLES) : gcnt;
      idx_n = idx == 3'd6 ? idx : idx + 3'd1;
      sr_n = idx == 3'd6 ? sr : sr >> 1;
    end else if (gap_done) begin
      state_n = IDLE;
    end else if (state == GAP) begin
      gcnt_n = gcnt - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= 2'd0;
      wp <= 1'b0;
      rp <= 1'b0;
      sr <= 7'd0;
      idx <= 3'd0;
      gcnt <= 4'd0;
      strobe <= 1'b0;
      d_out <= 1'b0;
      frames_sent <= 8'd0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      idx <= idx_n;
      gcnt <= gcnt_n;
      strobe <= state_n == SEND;
      d_out <= state_n == SEND && sr_n[0];
      if (push) begin
        mem[wp] <= in_data;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (state == SEND && idx == 3'd6) frames_sent <= frames_sent + 8'd1;
    end
  end
endmodule

// File: tb/tb_hamming_serial_tx.sv
// tb_hamming_serial_tx: directed checks on two instances (GAP_CYCLES 1 and 3) sharing inputs
module tb_hamming_serial_tx;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic in_ready1, strobe1, d_out1, busy1, in_ready3, strobe3, d_out3, busy3;
  logic [7:0] frames1, frames3;
  logic [63:0] s1, d1, s3, d3;
  int nlog, acc, errors, checks;
  hamming_serial_tx #(.GAP_CYCLES(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .strobe(strobe1), .d_out(d_out1), .busy(busy1), .frames_sent(frames1));
  hamming_serial_tx #(.GAP_CYCLES(3)) u3 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready3), .strobe(strobe3), .d_out(d_out3), .busy(busy3), .frames_sent(frames3));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      if (in_valid && in_ready3) acc++;
      tick;
      if (nlog < 64) begin
        s1[nlog] = strobe1; d1[nlog] = d_out1; s3[nlog] = strobe3; d3[nlog] = d_out3;
      end
      nlog++;
    end
  endtask
  task automatic do_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = 4'd0;
    tick;
    rst = 1'b0; nlog = 0; acc = 0; s1 = '0; d1 = '0; s3 = '0; d3 = '0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    checks++; if (strobe1 !== 1'b0) begin errors++; $display("FAIL rst_strobe: got %b want 0", strobe1); end
    checks++; if (d_out1 !== 1'b0) begin errors++; $display("FAIL rst_d_out: got %b want 0", d_out1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready1); end
    checks++; if (frames1 !== 8'd0) begin errors++; $display("FAIL rst_frames: got %0d want 0", frames1); end
  endtask
  task automatic test_single;
    do_reset;
    in_valid = 1'b1; in_data = 4'b1011;
    tick;
    in_valid = 1'b0;
    cap(7);
    checks++; if (frames1 !== 8'd0) begin errors++; $display("FAIL single_frames_mid: got %0d want 0", frames1); end
    cap(1);
    checks++; if (frames1 !== 8'd1) begin errors++; $display("FAIL single_frames_end: got %0d want 1", frames1); end
    checks++; if (s1[7:0] !== 8'h7F) begin errors++; $display("FAIL single_strobe: got %h want 7f", s1[7:0]); end
    checks++; if (d1[7:0] !== 8'h55) begin errors++; $display("FAIL single_bits: got %h want 55", d1[7:0]); end
    checks++; if (s3[7:0] !== 8'h7F || d3[7:0] !== 8'h55) begin errors++; $display("FAIL single_gap3: got %h/%h want 7f/55", s3[7:0], d3[7:0]); end
  endtask
  task automatic test_back_to_back;
    do_reset;
    in_valid = 1'b1; in_data = 4'b0001;
    tick;
    in_data = 4'b1111;
    cap(1);
    in_valid = 1'b0;
    cap(15);
    checks++; if (s1[15:0] !== 16'h7F7F) begin errors++; $display("FAIL b2b_strobe: got %h want 7f7f", s1[15:0]); end
    checks++; if (d1[15:0] !== 16'h7F07) begin errors++; $display("FAIL b2b_bits: got %h want 7f07", d1[15:0]); end
    checks++; if (frames1 !== 8'd2) begin errors++; $display("FAIL b2b_frames: got %0d want 2", frames1); end
  endtask
  task automatic test_continuous;
    int rises, bad;
    do_reset;
    in_valid = 1'b1; in_data = 4'b0000;
    cap(2);
    checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL cont_ready_2: got %b want 1", in_ready3); end
    cap(1);
    checks++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL cont_ready_3: got %b want 0", in_ready3); end
    cap(27);
    in_valid = 1'b0;
    cap(21);
    rises = 0; bad = 0;
    for (int k = 1; k <= 50; k++)
      if (s3[k] && !s3[k-1]) begin
        if (k != 1 + 10 * rises) bad++;
        rises++;
      end
    checks++; if (acc !== 5) begin errors++; $display("FAIL cont_accepted: got %0d want 5", acc); end
    checks++; if (frames3 !== 8'd5) begin errors++; $display("FAIL cont_frames: got %0d want 5", frames3); end
    checks++; if (rises !== 5 || bad !== 0) begin errors++; $display("FAIL cont_period: got rises=%0d misplaced=%0d want 5/0", rises, bad); end
    checks++; if ($countones(s3[50:0]) !== 35) begin errors++; $display("FAIL cont_strobe_cycles: got %0d want 35", $countones(s3[50:0])); end
    checks++; if (d3[50:0] !== 51'd0) begin errors++; $display("FAIL cont_bits: got %h want 0", d3[50:0]); end
  endtask
  task automatic test_reset_mid_frame;
    do_reset;
    in_valid = 1'b1; in_data = 4'b0001;
    tick;
    in_data = 4'b1111;
    tick;
    in_data = 4'b1011;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    checks++; if (strobe1 !== 1'b1 || in_ready1 !== 1'b0) begin errors++; $display("FAIL mid_setup: got strobe=%b ready=%b want 1/0", strobe1, in_ready1); end
    rst = 1'b1; in_valid = 1'b1; in_data = 4'b0110;
    tick;
    checks++; if (strobe1 !== 1'b0) begin errors++; $display("FAIL mid_strobe: got %b want 0", strobe1); end
    checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", in_ready1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy1); end
    checks++; if (frames1 !== 8'd0) begin errors++; $display("FAIL mid_frames: got %0d want 0", frames1); end
    tick;
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL mid_rst_priority: got busy=%b/%b want 0/0", busy1, busy3); end
    nlog = 0; s1 = '0; s3 = '0;
    cap(20);
    checks++; if (s1[19:0] !== 20'd0 || s3[19:0] !== 20'd0) begin errors++; $display("FAIL mid_no_frames: got %h/%h want 0/0", s1[19:0], s3[19:0]); end
    checks++; if (frames1 !== 8'd0) begin errors++; $display("FAIL mid_frames_after: got %0d want 0", frames1); end
  endtask
  task automatic test_wrap;
    bit seen;
    do_reset;
    in_data = 4'b1011; seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      in_valid = acc < 256;
      if (in_valid && in_ready1) acc++;
      tick;
      if (frames1 == 8'd255) seen = 1'b1;
    end
    in_valid = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL wrap_reach_255: got frames=%0d want 255", frames1); end
    checks++; if (acc !== 256) begin errors++; $display("FAIL wrap_accepted: got %0d want 256", acc); end
    nlog = 0;
    cap(8);
    checks++; if (frames1 !== 8'd0) begin errors++; $display("FAIL wrap_frames: got %0d want 0", frames1); end
    checks++; if (s1[7:0] !== 8'h7F || d1[7:0] !== 8'h55) begin errors++; $display("FAIL wrap_framing: got %h/%h want 7f/55", s1[7:0], d1[7:0]); end
  endtask
  task automatic test_push_pop_same_edge;
    do_reset;
    in_valid = 1'b1; in_data = 4'b0001;
    tick;
    in_valid = 1'b0;
    cap(1);
    in_valid = 1'b1; in_data = 4'b1111;
    cap(1);
    in_valid = 1'b0;
    cap(6);
    checks++; if (in_ready1 !== 1'b1 || strobe1 !== 1'b0) begin errors++; $display("FAIL pp_setup: got ready=%b strobe=%b want 1/0", in_ready1, strobe1); end
    in_valid = 1'b1; in_data = 4'b1011;
    cap(1);
    in_valid = 1'b0;
    checks++; if (in_ready1 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL pp_ready: got ready=%b busy=%b want 1/1", in_ready1, busy1); end
    cap(15);
    checks++; if (s1[23:0] !== 24'h7F7F7F) begin errors++; $display("FAIL pp_strobe: got %h want 7f7f7f", s1[23:0]); end
    checks++; if (d1[23:0] !== 24'h557F07) begin errors++; $display("FAIL pp_order: got %h want 557f07", d1[23:0]); end
    checks++; if (frames1 !== 8'd3) begin errors++; $display("FAIL pp_frames: got %0d want 3", frames1); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
  initial begin
    errors = 0; checks = 0; nlog = 0; acc = 0;
    test_reset;
    test_single;
    test_back_to_back;
    test_continuous;
    test_reset_mid_frame;
    test_push_pop_same_edge;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
